// File: rtl/kernel_pkg.sv
// Shared definitions for the kernel window writer family.
//   KP_ADDR_W / KP_DATA_W : default coordinate and sample widths (8x8 tile, 8-bit pixels)
//   MAX_COORD             : highest legal coordinate, used as the right-edge clamp limit
//   kw_state_e            : sequencing states of the window writer
package kernel_pkg;

    localparam int KP_ADDR_W = 3;
    localparam int KP_DATA_W = 8;

    localparam logic [KP_ADDR_W-1:0] MAX_COORD = {KP_ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_L = 3'd1,
        ST_RD_C = 3'd2,
        ST_RD_R = 3'd3,
        ST_CAPT = 3'd4,
        ST_OUT  = 3'd5
    } kw_state_e;

endpackage

// File: rtl/kernel_tap121.sv
// Combinational [1,2,1] smoothing tap with round-half-up.
//   tap_l, tap_c, tap_r : left, centre, right samples (DATA_W bits)
//   tap_y               : floor((l + 2c + r + 2) / 4), always fits DATA_W bits
// The sum is carried in DATA_W+2 bits so the worst case (all ones) cannot overflow.
module kernel_tap121
    import kernel_pkg::*;
#(
    parameter int DATA_W = KP_DATA_W
) (
    input  logic [DATA_W-1:0] tap_l,
    input  logic [DATA_W-1:0] tap_c,
    input  logic [DATA_W-1:0] tap_r,
    output logic [DATA_W-1:0] tap_y
);

    logic [DATA_W+1:0] sum_s;

    // Weighted sum with rounding constant, then divide by four.
    always_comb begin
        sum_s = {2'b00, tap_l}
              + {1'b0, tap_c, 1'b0}
              + {2'b00, tap_r}
              + {{DATA_W{1'b0}}, 2'b10};
        tap_y = DATA_W'(sum_s >> 2'd2);
    end

endmodule

// File: rtl/kernel_window_writer.sv
// Fetches the left/centre/right neighbours of one centre pixel through a
// single-port, 1-cycle-latency memory and emits the [1,2,1]-smoothed sample
// tagged with the centre address.
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready/in_width/in_depth : centre address handshake
//   rd_en/rd_width/rd_depth/rd_data    : image memory read port (data 1 cycle after rd_en)
//   out_valid/out_ready/out_width/out_depth/out_data : result handshake
// Neighbour widths are clamped at the tile edges (replicate, never wrap);
// the depth coordinate passes through untouched. All outputs are registered.
module kernel_window_writer
    import kernel_pkg::*;
#(
    parameter int ADDR_W = KP_ADDR_W,
    parameter int DATA_W = KP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_width,
    input  logic [ADDR_W-1:0] in_depth,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_width,
    output logic [ADDR_W-1:0] rd_depth,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_width,
    output logic [ADDR_W-1:0] out_depth,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] COORD_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] COORD_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] EDGE_HI    = {ADDR_W{1'b1}};

    kw_state_e         state_r;
    kw_state_e         next_state_s;
    logic [ADDR_W-1:0] w_r;
    logic [ADDR_W-1:0] d_r;
    logic [DATA_W-1:0] l_r;
    logic [DATA_W-1:0] c_r;
    logic              in_ready_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_width_r;
    logic [ADDR_W-1:0] rd_depth_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_width_r;
    logic [ADDR_W-1:0] out_depth_r;
    logic [DATA_W-1:0] out_data_r;

    logic [ADDR_W-1:0] w_sel_s;
    logic [ADDR_W-1:0] d_sel_s;
    logic [ADDR_W-1:0] lw_s;
    logic [ADDR_W-1:0] rw_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_width_s;
    logic [ADDR_W-1:0] rd_depth_s;
    logic [DATA_W-1:0] tap_y_s;

    kernel_tap121 #(.DATA_W(DATA_W)) u_tap (
        .tap_l (l_r),
        .tap_c (c_r),
        .tap_r (rd_data),
        .tap_y (tap_y_s)
    );

    // Next-state sequencing: one pass through the three reads per accepted centre.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state_s = ST_RD_L;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_L: next_state_s = ST_RD_C;
            ST_RD_C: next_state_s = ST_RD_R;
            ST_RD_R: next_state_s = ST_CAPT;
            ST_CAPT: next_state_s = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Read address for the coming cycle. The left read is issued straight out of
    // IDLE, before the centre is latched, so the live input is used there.
    always_comb begin
        w_sel_s    = (state_r == ST_IDLE) ? in_width : w_r;
        d_sel_s    = (state_r == ST_IDLE) ? in_depth : d_r;
        lw_s       = (w_sel_s == COORD_ZERO) ? w_sel_s : (w_sel_s - COORD_ONE);
        rw_s       = (w_sel_s == EDGE_HI)    ? w_sel_s : (w_sel_s + COORD_ONE);
        rd_en_s    = 1'b0;
        rd_width_s = COORD_ZERO;
        rd_depth_s = COORD_ZERO;
        case (next_state_s)
            ST_RD_L: begin
                rd_en_s    = 1'b1;
                rd_width_s = lw_s;
                rd_depth_s = d_sel_s;
            end
            ST_RD_C: begin
                rd_en_s    = 1'b1;
                rd_width_s = w_sel_s;
                rd_depth_s = d_sel_s;
            end
            ST_RD_R: begin
                rd_en_s    = 1'b1;
                rd_width_s = rw_s;
                rd_depth_s = d_sel_s;
            end
            default: begin
                rd_en_s    = 1'b0;
                rd_width_s = COORD_ZERO;
                rd_depth_s = COORD_ZERO;
            end
        endcase
    end

    // State, sample capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            w_r         <= COORD_ZERO;
            d_r         <= COORD_ZERO;
            l_r         <= {DATA_W{1'b0}};
            c_r         <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b1;
            rd_en_r     <= 1'b0;
            rd_width_r  <= COORD_ZERO;
            rd_depth_r  <= COORD_ZERO;
            out_valid_r <= 1'b0;
            out_width_r <= COORD_ZERO;
            out_depth_r <= COORD_ZERO;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            rd_en_r     <= rd_en_s;
            rd_width_r  <= rd_width_s;
            rd_depth_r  <= rd_depth_s;
            out_valid_r <= (next_state_s == ST_OUT);
            if ((state_r == ST_IDLE) && in_valid) begin
                w_r <= in_width;
                d_r <= in_depth;
            end
            // rd_data in RD_C answers the left read, in RD_R the centre read;
            // the right sample is consumed directly in CAPT.
            if (state_r == ST_RD_C) begin
                l_r <= rd_data;
            end
            if (state_r == ST_RD_R) begin
                c_r <= rd_data;
            end
            if (state_r == ST_CAPT) begin
                out_data_r  <= tap_y_s;
                out_width_r <= w_r;
                out_depth_r <= d_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign rd_en     = rd_en_r;
    assign rd_width  = rd_width_r;
    assign rd_depth  = rd_depth_r;
    assign out_valid = out_valid_r;
    assign out_width = out_width_r;
    assign out_depth = out_depth_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_kernel_window_writer.sv
// Directed self-checking bench for kernel_window_writer with an 8x8 image
// memory model that answers one cycle after rd_en and drives a junk value
// otherwise, so mistimed captures show up as wrong results.
module tb_kernel_window_writer;
    import kernel_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_width;
    logic [2:0] in_depth;
    logic       rd_en;
    logic [2:0] rd_width;
    logic [2:0] rd_depth;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_width;
    logic [2:0] out_depth;
    logic [7:0] out_data;

    logic [7:0] mem [0:7][0:7];

    int checks   = 0;
    int failures = 0;

    kernel_window_writer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_width  (in_width),
        .in_depth  (in_depth),
        .rd_en     (rd_en),
        .rd_width  (rd_width),
        .rd_depth  (rd_depth),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_width (out_width),
        .out_depth (out_depth),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Memory model: 1-cycle read latency, junk when no read was issued.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_depth][rd_width];
        else       rd_data <= 8'hEE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One centre transaction, accepted at the end of the current cycle (T).
    task automatic txn(input string tag, input logic [2:0] w, input logic [2:0] d,
                       input logic [2:0] lw, input logic [2:0] rw,
                       input logic [7:0] exp, input int stall, input bit keep);
        in_width = w;
        in_depth = d;
        in_valid = 1'b1;
        chk({tag, "_accept_ready"}, in_ready, 1'b1);
        tick();                                                  // T+1
        if (!keep) in_valid = 1'b0;
        chk({tag, "_rdL_en"}, rd_en, 1'b1);
        chk({tag, "_rdL_addr"}, {rd_width, rd_depth}, {lw, d});
        chk({tag, "_busy_ready"}, in_ready, 1'b0);
        tick();                                                  // T+2
        chk({tag, "_rdC_en"}, rd_en, 1'b1);
        chk({tag, "_rdC_addr"}, {rd_width, rd_depth}, {w, d});
        tick();                                                  // T+3
        chk({tag, "_rdR_en"}, rd_en, 1'b1);
        chk({tag, "_rdR_addr"}, {rd_width, rd_depth}, {rw, d});
        tick();                                                  // T+4
        chk({tag, "_capt_rd_en"}, rd_en, 1'b0);
        chk({tag, "_capt_out_valid"}, out_valid, 1'b0);
        tick();                                                  // T+5
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_out_data"}, out_data, exp);
        chk({tag, "_out_addr"}, {out_width, out_depth}, {w, d});
        chk({tag, "_out_in_ready"}, in_ready, 1'b0);
        if (stall > 0) out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_fields"}, {out_data, out_width, out_depth}, {exp, w, d});
            chk({tag, "_hold_rd_en"}, rd_en, 1'b0);
            chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();                                                  // cycle after handshake
        chk({tag, "_post_valid"}, out_valid, 1'b0);
        chk({tag, "_post_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        for (int dd = 0; dd < 8; dd++)
            for (int ww = 0; ww < 8; ww++)
                mem[dd][ww] = 8'(dd * 8 + ww) ^ 8'h5A;
        mem[5][2] = 8'd10;  mem[5][3] = 8'd20;  mem[5][4] = 8'd30;
        mem[2][0] = 8'd100; mem[2][1] = 8'd40;
        mem[7][6] = 8'd255; mem[7][7] = 8'd255;
        mem[1][0] = 8'd4;   mem[1][1] = 8'd8;   mem[1][2] = 8'd16;
        mem[0][4] = 8'd1;   mem[0][5] = 8'd2;   mem[0][6] = 8'd3;
        mem[3][5] = 8'd50;  mem[3][6] = 8'd60;  mem[3][7] = 8'd70;
        mem[6][1] = 8'd0;   mem[6][2] = 8'd0;   mem[6][3] = 8'd3;
        mem[4][3] = 8'd200; mem[4][4] = 8'd100; mem[4][5] = 8'd0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_width  = 3'd0;
        in_depth  = 3'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_rd", {rd_en, rd_width, rd_depth}, 7'd0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_fields", {out_data, out_width, out_depth}, 14'd0);
        tick();

        // (10 + 40 + 30 + 2) / 4 = 20
        txn("interior", 3'd3, 3'd5, 3'd2, 3'd4, 8'd20, 0, 1'b0);
        // (100 + 200 + 40 + 2) / 4 = 85, left edge replicated
        txn("left_edge", 3'd0, 3'd2, 3'd0, 3'd1, 8'd85, 0, 1'b0);
        // (255 + 510 + 255 + 2) / 4 = 255, right edge replicated, no overflow
        txn("right_edge", MAX_COORD, 3'd7, 3'd6, 3'd7, 8'd255, 0, 1'b0);
        // Same window as interior, output held for 10 cycles
        txn("backpressure", 3'd3, 3'd5, 3'd2, 3'd4, 8'd20, 10, 1'b0);

        // Abandon a transaction while the centre read is in flight.
        in_width = 3'd6;
        in_depth = 3'd6;
        in_valid = 1'b1;
        tick();                                  // RD_L
        in_valid = 1'b0;
        tick();                                  // RD_C
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rd_en", rd_en, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_quiet", {out_valid, rd_en}, 2'b00);
        end
        // (4 + 16 + 16 + 2) / 4 = 9
        txn("after_reset", 3'd1, 3'd1, 3'd0, 3'd2, 8'd9, 0, 1'b0);

        // Back-to-back with in_valid held high: accepted every 6 cycles.
        txn("b2b0", 3'd5, 3'd0, 3'd4, 3'd6, 8'd2, 0, 1'b1);    // (1+4+3+2)/4
        txn("b2b1", 3'd6, 3'd3, 3'd5, 3'd7, 8'd60, 0, 1'b1);   // (50+120+70+2)/4
        txn("b2b2", 3'd2, 3'd6, 3'd1, 3'd3, 8'd1, 0, 1'b1);    // (0+0+3+2)/4
        txn("b2b3", 3'd4, 3'd4, 3'd3, 3'd5, 8'd100, 0, 1'b0);  // (200+200+0+2)/4

        tick();
        chk("final_idle_rd_en", rd_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
